// File: rtl/mem_pkg.sv
// Shared memory-subsystem types: arbitration modes, technology and clock descriptors.
package mem_pkg;

  typedef enum logic {
    MEM_ARBITER_ROUND_ROBIN    = 1'b0,
    MEM_ARBITER_FIXED_PRIORITY = 1'b1
  } mem_arbiter_mode_t;

  typedef enum logic [1:0] {
    STD_TECHNOLOGY_FPGA_XILINX = 2'd0,
    STD_TECHNOLOGY_FPGA_INTEL  = 2'd1,
    STD_TECHNOLOGY_ASIC        = 2'd2
  } std_technology_t;

  typedef logic [31:0] std_clock_info_t;

endpackage

// File: rtl/mem_arbiter_route_fifo.sv
// Register-based FIFO holding the requester index of each outstanding read,
// so results coming back in issue order can be steered to their owner.
module mem_arbiter_route_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  // A pop in the same cycle does not free a slot for a push when full.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = entries[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-port memory arbiter: grants one requester per cycle into a registered
// memory request and steers in-order read results back to their issuer.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter std_clock_info_t   CLOCK_INFO      = 'b0,
  parameter std_technology_t   TECHNOLOGY      = STD_TECHNOLOGY_FPGA_XILINX,
  parameter int                PORTS           = 3,
  parameter int                DATA_WIDTH      = 32,
  parameter int                ADDR_WIDTH      = 32,
  parameter int                MAX_OUTSTANDING = 4,
  parameter mem_arbiter_mode_t MODE            = MEM_ARBITER_ROUND_ROBIN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS-1:0]                 mem_in_valid,
  output logic [PORTS-1:0]                 mem_in_ready,
  input  logic [PORTS-1:0]                 mem_in_read_write,
  input  logic [PORTS*(DATA_WIDTH/8)-1:0]  mem_in_write_enable,
  input  logic [PORTS*ADDR_WIDTH-1:0]      mem_in_addr,
  input  logic [PORTS*DATA_WIDTH-1:0]      mem_in_data,
  output logic [PORTS-1:0]                 mem_out_valid,
  input  logic [PORTS-1:0]                 mem_out_ready,
  output logic [PORTS*DATA_WIDTH-1:0]      mem_out_data,
  output logic                             mem_request_valid,
  input  logic                             mem_request_ready,
  output logic                             mem_request_read_write,
  output logic [DATA_WIDTH/8-1:0]          mem_request_write_enable,
  output logic [ADDR_WIDTH-1:0]            mem_request_addr,
  output logic [DATA_WIDTH-1:0]            mem_request_data,
  input  logic                             mem_result_valid,
  output logic                             mem_result_ready,
  input  logic [DATA_WIDTH-1:0]            mem_result_data,
  output logic                             error
);

  localparam int IDX_W = $clog2(PORTS);
  localparam int BE_W  = DATA_WIDTH / 8;

  logic [PORTS-1:0] cand;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic             accept;
  logic [IDX_W-1:0] rr_ptr;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [IDX_W-1:0] fifo_head;

  // Reads are held back while every result slot is already spoken for.
  always_comb begin
    cand        = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < PORTS; i++)
      cand[i] = mem_in_valid[i] && (mem_in_read_write[i] || !fifo_full);
    if (MODE == MEM_ARBITER_FIXED_PRIORITY) begin
      for (int i = PORTS - 1; i >= 0; i--) begin
        if (cand[i]) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < PORTS; k++) begin
        if (!grant_found && cand[(int'(rr_ptr) + k) % PORTS]) begin
          grant_found = 1'b1;
          grant_idx   = IDX_W'((int'(rr_ptr) + k) % PORTS);
        end
      end
    end
  end

  assign accept = rst && grant_found && (!mem_request_valid || mem_request_ready);

  always_comb begin
    mem_in_ready = '0;
    if (accept) mem_in_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_request_valid        <= 1'b0;
      mem_request_read_write   <= 1'b0;
      mem_request_write_enable <= '0;
      mem_request_addr         <= '0;
      mem_request_data         <= '0;
    end else if (accept) begin
      mem_request_valid        <= 1'b1;
      mem_request_read_write   <= mem_in_read_write[grant_idx];
      mem_request_write_enable <= mem_in_write_enable[int'(grant_idx)*BE_W +: BE_W];
      mem_request_addr         <= mem_in_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      mem_request_data         <= mem_in_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end else if (mem_request_ready) begin
      mem_request_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;
  end

  mem_arbiter_route_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_route_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept && !mem_in_read_write[grant_idx]),
    .push_data (grant_idx),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // With nothing outstanding, results are drained and flagged as errors.
  always_comb begin
    mem_out_valid    = '0;
    mem_result_ready = 1'b1;
    fifo_pop         = 1'b0;
    if (!fifo_empty) begin
      mem_out_valid[fifo_head] = mem_result_valid;
      mem_result_ready         = mem_out_ready[fifo_head];
      fifo_pop                 = mem_result_valid && mem_out_ready[fifo_head];
    end
  end

  assign mem_out_data = {PORTS{mem_result_data}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      error <= 1'b0;
    else if (fifo_empty && mem_result_valid)
      error <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a round-robin and a fixed-priority instance
// run side by side against a queue-based model of the arbitration rules.
module tb_mem_arbiter;
  import mem_pkg::*;

  localparam int P  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int MO = 4;
  localparam int NI = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [P-1:0]    in_valid  [NI];
  logic [P-1:0]    in_ready  [NI];
  logic [P-1:0]    in_rw     [NI];
  logic [P*BW-1:0] in_we     [NI];
  logic [P*AW-1:0] in_addr   [NI];
  logic [P*DW-1:0] in_data   [NI];
  logic [P-1:0]    out_valid [NI];
  logic [P-1:0]    out_ready [NI];
  logic [P*DW-1:0] out_data  [NI];
  logic            req_valid [NI];
  logic            req_ready [NI];
  logic            req_rw    [NI];
  logic [BW-1:0]   req_we    [NI];
  logic [AW-1:0]   req_addr  [NI];
  logic [DW-1:0]   req_data  [NI];
  logic            res_valid [NI];
  logic            res_ready [NI];
  logic [DW-1:0]   res_data  [NI];
  logic            err       [NI];

  mem_arbiter #(
    .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO),
    .MODE(MEM_ARBITER_ROUND_ROBIN)
  ) u_rr (
    .clk(clk), .rst(rst),
    .mem_in_valid(in_valid[0]), .mem_in_ready(in_ready[0]), .mem_in_read_write(in_rw[0]),
    .mem_in_write_enable(in_we[0]), .mem_in_addr(in_addr[0]), .mem_in_data(in_data[0]),
    .mem_out_valid(out_valid[0]), .mem_out_ready(out_ready[0]), .mem_out_data(out_data[0]),
    .mem_request_valid(req_valid[0]), .mem_request_ready(req_ready[0]),
    .mem_request_read_write(req_rw[0]), .mem_request_write_enable(req_we[0]),
    .mem_request_addr(req_addr[0]), .mem_request_data(req_data[0]),
    .mem_result_valid(res_valid[0]), .mem_result_ready(res_ready[0]),
    .mem_result_data(res_data[0]), .error(err[0])
  );

  mem_arbiter #(
    .PORTS(P), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_OUTSTANDING(MO),
    .MODE(MEM_ARBITER_FIXED_PRIORITY)
  ) u_fp (
    .clk(clk), .rst(rst),
    .mem_in_valid(in_valid[1]), .mem_in_ready(in_ready[1]), .mem_in_read_write(in_rw[1]),
    .mem_in_write_enable(in_we[1]), .mem_in_addr(in_addr[1]), .mem_in_data(in_data[1]),
    .mem_out_valid(out_valid[1]), .mem_out_ready(out_ready[1]), .mem_out_data(out_data[1]),
    .mem_request_valid(req_valid[1]), .mem_request_ready(req_ready[1]),
    .mem_request_read_write(req_rw[1]), .mem_request_write_enable(req_we[1]),
    .mem_request_addr(req_addr[1]), .mem_request_data(req_data[1]),
    .mem_result_valid(res_valid[1]), .mem_result_ready(res_ready[1]),
    .mem_result_data(res_data[1]), .error(err[1])
  );

  // Reference model state: pending request slot, outstanding-read owners,
  // memory-side read queue and per-port expected result addresses.
  int            m_rr    [NI];
  int            m_rq    [NI][$];
  bit            m_ov    [NI];
  bit            m_orw   [NI];
  logic [BW-1:0] m_owe   [NI];
  logic [AW-1:0] m_oaddr [NI];
  logic [DW-1:0] m_odata [NI];
  bit            m_err   [NI];
  logic [AW-1:0] memq    [NI][$];
  logic [AW-1:0] sb      [NI*P][$];

  bit e_acc [NI];
  int e_g   [NI];
  bit e_pop [NI];
  bit e_set [NI];

  int checks   = 0;
  int failures = 0;
  int p_valid, p_read, p_req_ready, p_res, p_out_ready;
  bit spurious;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic resetModel();
    for (int n = 0; n < NI; n++) begin
      m_rr[n] = 0;
      m_rq[n].delete();
      m_ov[n] = 1'b0;
      m_err[n] = 1'b0;
      memq[n].delete();
    end
    for (int k = 0; k < NI*P; k++) sb[k].delete();
  endtask

  task automatic quietInputs();
    for (int n = 0; n < NI; n++) begin
      in_valid[n] = '0; in_rw[n] = '0; in_we[n] = '0; in_addr[n] = '0; in_data[n] = '0;
      out_ready[n] = '1; req_ready[n] = 1'b1; res_valid[n] = 1'b0; res_data[n] = '0;
    end
  endtask

  task automatic applyStimulus(input int n);
    for (int i = 0; i < P; i++) begin
      in_valid[n][i] = ($urandom_range(99) < p_valid);
      in_rw[n][i]    = !($urandom_range(99) < p_read);
      in_we[n][i*BW +: BW] = BW'($urandom());
      in_addr[n][i*AW +: AW] = $urandom();
      in_data[n][i*DW +: DW] = $urandom();
      out_ready[n][i] = ($urandom_range(99) < p_out_ready);
    end
    req_ready[n] = ($urandom_range(99) < p_req_ready);
    res_data[n]  = $urandom();
    res_valid[n] = 1'b0;
    if (memq[n].size() > 0 && $urandom_range(99) < p_res) begin
      res_valid[n] = 1'b1;
      res_data[n]  = memq[n][0];
    end else if (spurious && memq[n].size() == 0 && m_rq[n].size() == 0) begin
      res_valid[n] = 1'b1;
    end
  endtask

  task automatic checkCycle(input int n);
    bit full;
    int g, h;
    logic [P-1:0] e_ready, e_outv;
    logic e_resr;
    string pfx;
    pfx  = (n == 0) ? "rr" : "fp";
    full = (m_rq[n].size() == MO);
    g = -1;
    for (int k = 0; k < P; k++) begin
      int j;
      j = (n == 0) ? (m_rr[n] + k) % P : k;
      if (g < 0 && in_valid[n][j] && (in_rw[n][j] || !full)) g = j;
    end
    e_acc[n] = (g >= 0) && (!m_ov[n] || req_ready[n]);
    e_g[n]   = g;
    e_ready  = '0;
    if (e_acc[n]) e_ready[g] = 1'b1;
    e_outv = '0; e_resr = 1'b1; e_pop[n] = 1'b0; e_set[n] = 1'b0; h = 0;
    if (m_rq[n].size() > 0) begin
      h = m_rq[n][0];
      e_outv[h] = res_valid[n];
      e_resr    = out_ready[n][h];
      e_pop[n]  = res_valid[n] && out_ready[n][h];
    end else begin
      e_set[n] = res_valid[n];
    end
    checkOutput({pfx, " in_ready"},   64'(in_ready[n]),  64'(e_ready));
    checkOutput({pfx, " out_valid"},  64'(out_valid[n]), 64'(e_outv));
    checkOutput({pfx, " res_ready"},  64'(res_ready[n]), 64'(e_resr));
    checkOutput({pfx, " req_valid"},  64'(req_valid[n]), 64'(m_ov[n]));
    checkOutput({pfx, " error"},      64'(err[n]),       64'(m_err[n]));
    if (m_ov[n]) begin
      checkOutput({pfx, " req_rw"},   64'(req_rw[n]),   64'(m_orw[n]));
      checkOutput({pfx, " req_we"},   64'(req_we[n]),   64'(m_owe[n]));
      checkOutput({pfx, " req_addr"}, 64'(req_addr[n]), 64'(m_oaddr[n]));
      checkOutput({pfx, " req_data"}, 64'(req_data[n]), 64'(m_odata[n]));
    end
    if (e_pop[n] && sb[n*P+h].size() > 0)
      checkOutput($sformatf("%s result_port%0d", pfx, h), 64'(out_data[n][h*DW +: DW]), 64'(sb[n*P+h][0]));
  endtask

  task automatic updateModel(input int n);
    int g;
    g = e_g[n];
    if (e_pop[n]) begin
      sb[n*P + m_rq[n][0]].pop_front();
      void'(m_rq[n].pop_front());
      if (memq[n].size() > 0) void'(memq[n].pop_front());
    end
    if (m_ov[n] && req_ready[n] && !m_orw[n]) memq[n].push_back(m_oaddr[n]);
    if (e_acc[n]) begin
      m_ov[n]    = 1'b1;
      m_orw[n]   = in_rw[n][g];
      m_owe[n]   = in_we[n][g*BW +: BW];
      m_oaddr[n] = in_addr[n][g*AW +: AW];
      m_odata[n] = in_data[n][g*DW +: DW];
      if (!in_rw[n][g]) begin
        m_rq[n].push_back(g);
        sb[n*P+g].push_back(in_addr[n][g*AW +: AW]);
      end
      m_rr[n] = (g + 1) % P;
    end else if (req_ready[n]) begin
      m_ov[n] = 1'b0;
    end
    if (e_set[n]) m_err[n] = 1'b1;
  endtask

  task automatic runCycles(input int count);
    repeat (count) begin
      @(negedge clk);
      for (int n = 0; n < NI; n++) applyStimulus(n);
      #1;
      for (int n = 0; n < NI; n++) checkCycle(n);
      @(posedge clk);
      for (int n = 0; n < NI; n++) updateModel(n);
    end
  endtask

  task automatic checkResetState(input string tag);
    for (int n = 0; n < NI; n++) begin
      checkOutput($sformatf("%s%0d req_valid", tag, n), 64'(req_valid[n]), 64'd0);
      checkOutput($sformatf("%s%0d in_ready", tag, n),  64'(in_ready[n]),  64'd0);
      checkOutput($sformatf("%s%0d out_valid", tag, n), 64'(out_valid[n]), 64'd0);
      checkOutput($sformatf("%s%0d error", tag, n),     64'(err[n]),       64'd0);
    end
  endtask

  task automatic setKnobs(input int v, input int r, input int rq, input int rs, input int o);
    p_valid = v; p_read = r; p_req_ready = rq; p_res = rs; p_out_ready = o;
  endtask

  initial begin
    spurious = 1'b0;
    quietInputs();
    for (int n = 0; n < NI; n++) in_valid[n] = '1;
    rst = 1'b0;
    resetModel();
    #2;
    checkResetState("reset");
    quietInputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    setKnobs(100, 100, 100, 100, 100); runCycles(30);
    setKnobs(60, 60, 70, 60, 70);      runCycles(600);
    setKnobs(80, 70, 100, 0, 100);     runCycles(40);
    setKnobs(80, 50, 0, 50, 60);       runCycles(10);
    setKnobs(70, 60, 60, 50, 50);      runCycles(600);
    setKnobs(0, 50, 100, 100, 100);    runCycles(40);

    spurious = 1'b1;
    setKnobs(0, 50, 100, 100, 100);    runCycles(3);
    spurious = 1'b0;
    #1;
    for (int n = 0; n < NI; n++)
      checkOutput($sformatf("error_sticky%0d", n), 64'(err[n]), 64'd1);
    runCycles(5);

    setKnobs(90, 60, 70, 60, 80);      runCycles(12);
    #2;
    rst = 1'b0;
    #1;
    checkResetState("midreset");
    resetModel();
    quietInputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;

    setKnobs(70, 60, 70, 60, 70);      runCycles(150);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
